// File: rtl/rca16_stream_accumulator.sv
// Stream accumulator built around an external 16-bit ripple-carry adder.
// Accepts LEN operands over a valid/ready handshake, feeds each one to the
// adder together with the running sum, and counts every carry-out so that
// {carry_cnt, acc} is the exact total of all operands.
module rca16_stream_accumulator #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CNT_W-1:0]       len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_sum,
   input  logic                   add_cout,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+CNT_W-1:0] out_sum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] carry_cnt;
   logic [CNT_W-1:0] remaining;
   logic             beat;

   // The adder is combinational: it sees the running sum and the offered
   // operand directly, and its result is registered on the accepting edge.
   assign add_a   = acc;
   assign add_b   = in_data;
   assign add_cin = 1'b0;
   assign out_sum = {carry_cnt, acc};
   assign beat    = in_valid & in_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode: a zero-length request goes straight to DONE, the
   // last beat (remaining==1) closes ACCUM, and DONE waits for the consumer.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (len != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (beat && (remaining == CNT_W'(1))) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Handshake and status outputs are pure functions of the state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

   // Datapath: clear on an accepted start, absorb adder result and carry on
   // every beat. carry_cnt cannot overflow since at most LEN-1 carries occur.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         carry_cnt <= '0;
         remaining <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            acc       <= '0;
            carry_cnt <= '0;
            remaining <= len;
         end else if ((state == ACCUM) && beat) begin
            acc       <= add_sum;
            carry_cnt <= carry_cnt + CNT_W'(add_cout);
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rca16_stream_accumulator.sv
// Directed bench for rca16_stream_accumulator. A behavioural ripple-carry
// adder stands in for RCA_16bit on the add_* ports. Inputs are driven and
// outputs sampled on the falling edge; the design acts on the rising edge.
module tb_rca16_stream_accumulator;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic                   clk;
   logic                   rst;
   logic                   start;
   logic [CNT_W-1:0]       len;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic                   add_cin;
   logic [WIDTH-1:0]       add_sum;
   logic                   add_cout;
   logic                   busy;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH+CNT_W-1:0] out_sum;

   int tests;
   int fails;
   int beats;
   logic [WIDTH-1:0] data_mem [0:255];

   rca16_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   // Stand-in for the external RCA_16bit.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Offers data_mem[0..n-1] while the block is accumulating, optionally with
   // random gaps, and counts accepted beats. Stops once out_valid rises or
   // the cycle budget runs out.
   task automatic feed(input int n, input bit gapped, output int nbeats);
      int idx;
      int cyc;
      idx    = 0;
      cyc    = 0;
      nbeats = 0;
      while (!out_valid && cyc < 3000) begin
         if (idx < n && (!gapped || $urandom_range(0, 2) != 0)) begin
            in_valid = 1'b1;
            in_data  = data_mem[idx];
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
         if (in_valid && in_ready) begin
            nbeats++;
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Pulses start with the given length; returns on the falling edge after
   // the start has been sampled.
   task automatic do_start(input logic [CNT_W-1:0] n);
      start = 1'b1;
      len   = n;
      @(negedge clk);
      start = 1'b0;
      len   = 8'hA5;
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      // reset state
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_add_a", 32'(add_a), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // T1: len=1, 0xFFFF; out_valid two cycles after start
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      do_start(8'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_add_cin", 32'(add_cin), 32'd0);
      check("t1_add_b", 32'(add_b), 32'h0000FFFF);
      check("t1_out_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_sum", 32'(out_sum), 32'h00FFFF);
      check("t1_in_ready_done", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t1_idle_valid", 32'(out_valid), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // T2: start right after the handshake; 0xFFFF + 0x0001 -> 0x010000
      data_mem[0] = 16'hFFFF;
      data_mem[1] = 16'h0001;
      do_start(8'd2);
      check("t2_add_a_cleared", 32'(add_a), 32'd0);
      in_valid = 1'b1;
      in_data  = data_mem[0];
      @(negedge clk);
      check("t2_add_a_running", 32'(add_a), 32'h0000FFFF);
      in_data = data_mem[1];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_out_sum", 32'(out_sum), 32'h010000);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // T3: len=0 -> DONE next cycle with zero result, no beat accepted
      in_valid = 1'b1;
      in_data  = 16'h1234;
      do_start(8'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_out_sum", 32'(out_sum), 32'd0);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("t3_out_sum_hold", 32'(out_sum), 32'd0);
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // T4: 255 x 0xFFFF with random gaps -> 0xFEFF01, exactly 255 beats
      for (int i = 0; i < 255; i++) data_mem[i] = 16'hFFFF;
      do_start(8'd255);
      feed(255, 1'b1, beats);
      check("t4_beats", 32'(beats), 32'd255);
      check("t4_out_valid", 32'(out_valid), 32'd1);
      check("t4_out_sum", 32'(out_sum), 32'hFEFF01);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // T5: 1+2+3 held in DONE for 5 cycles while start is pulsed
      data_mem[0] = 16'd1;
      data_mem[1] = 16'd2;
      data_mem[2] = 16'd3;
      do_start(8'd3);
      feed(3, 1'b0, beats);
      check("t5_beats", 32'(beats), 32'd3);
      for (int i = 0; i < 5; i++) begin
         start = (i == 1 || i == 3);
         len   = 8'd4;
         check("t5_hold_valid", 32'(out_valid), 32'd1);
         check("t5_hold_sum", 32'(out_sum), 32'd6);
         @(negedge clk);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t5_idle_valid", 32'(out_valid), 32'd0);
      check("t5_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("t5_no_queued_start", 32'(busy), 32'd0);

      // T6: reset after 3 of 10 beats, then a fresh 3+4
      for (int i = 0; i < 10; i++) data_mem[i] = 16'h0005;
      do_start(8'd10);
      in_valid = 1'b1;
      in_data  = 16'h0005;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("t6_partial", 32'(add_a), 32'd15);
      rst = 1'b1;
      #1;
      check("t6_rst_in_ready", 32'(in_ready), 32'd0);
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_out_sum", 32'(out_sum), 32'd0);
      check("t6_rst_add_a", 32'(add_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_idle_busy", 32'(busy), 32'd0);
      data_mem[0] = 16'd3;
      data_mem[1] = 16'd4;
      do_start(8'd2);
      feed(2, 1'b0, beats);
      check("t6_beats", 32'(beats), 32'd2);
      check("t6_out_valid", 32'(out_valid), 32'd1);
      check("t6_out_sum", 32'(out_sum), 32'd7);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t6_end_idle", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
